// File: rtl/hyster_pkg.sv
// Shared constants and scan-state encoding for the hysteresis stage.
package hyster_pkg;
  localparam int BIT_LENGTH = 5;
  localparam int SKIP_CNT   = 2;
  localparam int FEED_EXTRA = 3;
  localparam int WEAK       = 1;
  localparam int STRONG     = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } state_t;
endpackage

// File: rtl/hyster_addr_gen.sv
// Turns the row counter and feed index into three vertically adjacent read addresses
// plus an in-range lane mask; also forms the output write address from row and column.
module hyster_addr_gen #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 8,
  parameter int CW     = ADDR_W + 2
) (
  input  logic              rd_req,
  input  logic [CW-1:0]     row,
  input  logic [CW-1:0]     rd_idx,
  input  logic [CW-1:0]     wr_col,
  output logic [2:0]        lane_ok,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] rd_addr2,
  output logic [ADDR_W-1:0] wr_addr
);
  logic [CW-1:0] col;
  logic [CW-1:0] base;
  logic          col_ok;

  always_comb begin
    // Feed index 0 is the left pad column, so the image column is one less.
    col        = rd_idx - CW'(1);
    col_ok     = rd_req && (rd_idx >= CW'(1)) && (rd_idx <= CW'(IMG_W));
    base       = row * CW'(IMG_W) + col;
    lane_ok[0] = col_ok && (row != '0);
    lane_ok[1] = col_ok;
    lane_ok[2] = col_ok && ((row + CW'(1)) < CW'(IMG_H));
    rd_addr0   = lane_ok[0] ? ADDR_W'(base - CW'(IMG_W)) : '0;
    rd_addr1   = lane_ok[1] ? ADDR_W'(base) : '0;
    rd_addr2   = lane_ok[2] ? ADDR_W'(base + CW'(IMG_W)) : '0;
    wr_addr    = ADDR_W'(row * CW'(IMG_W) + wr_col);
  end
endmodule

// File: rtl/hyster_scan_ctrl.sv
// Raster-scan sequencer feeding the Hyster window unit and writing its edge bits to RAM.
// Each row takes IMG_W+6 cycles; the whole image finishes IMG_H*(IMG_W+6)+1 cycles after start.
module hyster_scan_ctrl
  import hyster_pkg::*;
#(
  parameter int BIT_LENGTH = hyster_pkg::BIT_LENGTH,
  parameter int IMG_W      = 16,
  parameter int IMG_H      = 16,
  parameter int ADDR_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr0,
  output logic [ADDR_W-1:0]     rd_addr1,
  output logic [ADDR_W-1:0]     rd_addr2,
  input  logic [BIT_LENGTH-1:0] rd_data0,
  input  logic [BIT_LENGTH-1:0] rd_data1,
  input  logic [BIT_LENGTH-1:0] rd_data2,
  output logic [BIT_LENGTH-1:0] hy_pix0,
  output logic [BIT_LENGTH-1:0] hy_pix1,
  output logic [BIT_LENGTH-1:0] hy_pix2,
  output logic                  hy_en,
  output logic                  hy_rst,
  input  logic                  hy_out,
  input  logic                  hy_rdy,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic                  wr_data
);
  localparam int CW = ADDR_W + 2;
  localparam logic [CW-1:0] K_LAST = CW'(IMG_W + FEED_EXTRA - 1);

  state_t        state, state_n;
  logic [CW-1:0] row, k, n;
  logic [1:0]    skip;
  logic [2:0]    lane_ok, lane_d;
  logic          rd_req, capturing;
  logic [CW-1:0] rd_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    busy      = (state != IDLE) && (state != DONE);
    done      = (state == DONE);
    hy_en     = (state == FEED);
    // The read for feed index k+1 goes out while index k is being fed.
    rd_req    = (state == CLR) || ((state == FEED) && (k != K_LAST));
    rd_idx    = (state == FEED) ? k + CW'(1) : '0;
    rd_en     = |lane_ok;
    capturing = ((state == FEED) || (state == DRAIN)) && hy_rdy &&
                (skip == 2'(SKIP_CNT)) && (n != CW'(IMG_W));
    wr_en     = capturing;
    wr_data   = capturing & hy_out;
    hy_pix0   = lane_d[0] ? rd_data0 : '0;
    hy_pix1   = lane_d[1] ? rd_data1 : '0;
    hy_pix2   = lane_d[2] ? rd_data2 : '0;
    case (state)
      IDLE:    if (start) state_n = CLR;
      CLR:     state_n = FEED;
      FEED:    if (k == K_LAST) state_n = DRAIN;
      DRAIN:   state_n = NEXT;
      NEXT:    state_n = (row == CW'(IMG_H - 1)) ? DONE : CLR;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row    <= '0;
      k      <= '0;
      n      <= '0;
      skip   <= '0;
      lane_d <= '0;
      hy_rst <= 1'b0;
    end else begin
      lane_d <= lane_ok;
      hy_rst <= (state_n == CLR);
      case (state)
        IDLE: if (start) row <= '0;
        CLR: begin
          k    <= '0;
          n    <= '0;
          skip <= '0;
        end
        FEED: k <= k + CW'(1);
        NEXT: if (row != CW'(IMG_H - 1)) row <= row + CW'(1);
        DONE: begin
          row <= '0;
          n   <= '0;
        end
        default: ;
      endcase
      // The window unit's first two readable samples of a row are warm-up output.
      if (((state == FEED) || (state == DRAIN)) && hy_rdy) begin
        if (skip != 2'(SKIP_CNT))   skip <= skip + 2'd1;
        else if (n != CW'(IMG_W))   n    <= n + CW'(1);
      end
    end
  end

  hyster_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W),
    .CW    (CW)
  ) u_addr_gen (
    .rd_req  (rd_req),
    .row     (row),
    .rd_idx  (rd_idx),
    .wr_col  (n),
    .lane_ok (lane_ok),
    .rd_addr0(rd_addr0),
    .rd_addr1(rd_addr1),
    .rd_addr2(rd_addr2),
    .wr_addr (wr_addr)
  );
endmodule

// File: tb/tb_hyster_scan_ctrl.sv
// Bench: two scan controllers (4x3 and 1x1) with behavioural image RAM, Hyster window model and output log.
module tb_hyster_scan_ctrl;
  import hyster_pkg::*;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic reset;
  logic clr_log;
  always #5 clk = ~clk;

  logic          start [2], busy [2], done [2], rd_en [2], hy_en [2], hy_rst [2];
  logic          hy_out [2], hy_rdy [2], wr_en [2], wr_data [2];
  logic [AW-1:0] rd_addr0 [2], rd_addr1 [2], rd_addr2 [2], wr_addr [2];
  logic [4:0]    rd_data0 [2], rd_data1 [2], rd_data2 [2];
  logic [4:0]    hy_pix0 [2], hy_pix1 [2], hy_pix2 [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    hyster_scan_ctrl #(
      .BIT_LENGTH(5),
      .IMG_W     (gi == 0 ? 4 : 1),
      .IMG_H     (gi == 0 ? 3 : 1),
      .ADDR_W    (AW)
    ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start[gi]),
      .busy    (busy[gi]),
      .done    (done[gi]),
      .rd_en   (rd_en[gi]),
      .rd_addr0(rd_addr0[gi]),
      .rd_addr1(rd_addr1[gi]),
      .rd_addr2(rd_addr2[gi]),
      .rd_data0(rd_data0[gi]),
      .rd_data1(rd_data1[gi]),
      .rd_data2(rd_data2[gi]),
      .hy_pix0 (hy_pix0[gi]),
      .hy_pix1 (hy_pix1[gi]),
      .hy_pix2 (hy_pix2[gi]),
      .hy_en   (hy_en[gi]),
      .hy_rst  (hy_rst[gi]),
      .hy_out  (hy_out[gi]),
      .hy_rdy  (hy_rdy[gi]),
      .wr_en   (wr_en[gi]),
      .wr_addr (wr_addr[gi]),
      .wr_data (wr_data[gi])
    );
  end

  logic [4:0]   img [2][256];
  logic [4:0]   win [2][3][3];
  int           hcnt [2];
  int           wcnt [2];
  logic [255:0] wbits [2];
  logic [255:0] wvals [2];

  // Edge if centre is strong, or weak with any strong 8-neighbour.
  function automatic logic is_edge(input int i);
    logic s;
    s = 1'b0;
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++)
        if (!(a == 1 && b == 1) && win[i][a][b] >= 5'(STRONG)) s = 1'b1;
    return (win[i][1][1] >= 5'(STRONG)) || ((win[i][1][1] == 5'(WEAK)) && s);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      rd_data0[i] <= rd_en[i] ? img[i][rd_addr0[i]] : 5'h1f;
      rd_data1[i] <= rd_en[i] ? img[i][rd_addr1[i]] : 5'h1f;
      rd_data2[i] <= rd_en[i] ? img[i][rd_addr2[i]] : 5'h1f;
      if (reset || hy_rst[i]) begin
        hcnt[i]   <= 0;
        hy_rdy[i] <= 1'b0;
        hy_out[i] <= 1'b0;
      end else begin
        hy_rdy[i] <= (hcnt[i] >= 1);
        hy_out[i] <= is_edge(i);
        if (hy_en[i]) begin
          for (int j = 0; j < 3; j++) begin
            win[i][2][j] <= win[i][1][j];
            win[i][1][j] <= win[i][0][j];
          end
          win[i][0][0] <= hy_pix0[i];
          win[i][0][1] <= hy_pix1[i];
          win[i][0][2] <= hy_pix2[i];
          hcnt[i] <= (hcnt[i] < 3) ? hcnt[i] + 1 : 3;
        end
      end
      if (clr_log) begin
        wcnt[i]  <= 0;
        wbits[i] <= '0;
        wvals[i] <= '0;
      end else if (wr_en[i]) begin
        wcnt[i]              <= wcnt[i] + 1;
        wbits[i][wr_addr[i]] <= 1'b1;
        wvals[i][wr_addr[i]] <= wr_data[i];
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    @(posedge clk); #1 clr_log = 1'b1;
    @(posedge clk); #1 clr_log = 1'b0;
  endtask

  task automatic run(input int i, input int budget, output int dcyc, output int b1,
                     output int nrst, output int nen, output int nruns, output int nhand);
    logic prev_en, prev_rst;
    prev_en = 1'b0; prev_rst = 1'b0;
    dcyc = -1; b1 = 0; nrst = 0; nen = 0; nruns = 0; nhand = 0;
    @(posedge clk); #1 start[i] = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1 start[i] = 1'b0;
      if (c == 1) b1 = int'(busy[i]);
      if (hy_rst[i]) nrst++;
      if (hy_en[i]) begin
        nen++;
        if (!prev_en) nruns++;
      end
      if (prev_rst && hy_en[i] && !hy_rst[i]) nhand++;
      prev_en  = hy_en[i];
      prev_rst = hy_rst[i];
      if (done[i]) begin
        dcyc = c;
        break;
      end
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy[0], 1'b0);
    chk({tag, "_strobes"}, {done[0], rd_en[0], hy_en[0], hy_rst[0], wr_en[0], wr_data[0]}, 6'b0);
    chk({tag, "_pix"}, {hy_pix0[0], hy_pix1[0], hy_pix2[0]}, 15'b0);
    chk({tag, "_addr"}, {rd_addr0[0], rd_addr1[0], rd_addr2[0], wr_addr[0]}, 32'b0);
  endtask

  task automatic full_run(input string tag, input logic [11:0] exp_bits);
    int dcyc, b1, nrst, nen, nruns, nhand;
    clear_log();
    run(0, 100, dcyc, b1, nrst, nen, nruns, nhand);
    chk({tag, "_done_cyc"}, dcyc, 31);
    chk({tag, "_busy_c1"}, b1, 1);
    chk({tag, "_rst_cycles"}, nrst, 3);
    chk({tag, "_en_cycles"}, nen, 3 * 7);
    chk({tag, "_en_runs"}, nruns, 3);
    chk({tag, "_rst_then_en"}, nhand, 3);
    chk({tag, "_wcnt"}, wcnt[0], 12);
    chk({tag, "_wmask"}, wbits[0][31:0], 32'hfff);
    chk({tag, "_stray"}, {31'b0, |wbits[0][255:32]}, 0);
    chk({tag, "_bits"}, wvals[0][31:0], {20'b0, exp_bits});
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {done[0], busy[0]}, 2'b00);
  endtask

  initial begin
    int dcyc, b1, nrst, nen, nruns, nhand, nr, nd, nb;
    reset = 1'b1; clr_log = 1'b0;
    start[0] = 1'b0; start[1] = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 256; a++) img[i][a] = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    reset = 1'b0;

    full_run("t1_zero", 12'h000);

    img[0][5] = 5'd1; img[0][6] = 5'd2;
    full_run("t2_centre", 12'h060);

    img[0][5] = 5'd0; img[0][6] = 5'd0;
    img[0][0] = 5'd1; img[0][11] = 5'd2;
    full_run("t3_corner", 12'h800);

    img[1][0] = 5'd3;
    clear_log();
    run(1, 50, dcyc, b1, nrst, nen, nruns, nhand);
    chk("t4_done_cyc", dcyc, 8);
    chk("t4_en_cycles", nen, 4);
    chk("t4_wcnt", wcnt[1], 1);
    chk("t4_bits", {wbits[1][1:0], wvals[1][1:0]}, 4'b0101);

    // Extra starts during busy, then reset mid-row 1.
    clear_log();
    nr = 0; nd = 0; nb = 0;
    @(posedge clk); #1 start[0] = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1 start[0] = (c == 3) || (c == 12);
      if (hy_rst[0]) nr++;
      if (done[0]) nd++;
      if (busy[0]) nb++;
    end
    chk("t5_rst_before", nr, 2);
    chk("t5_busy_before", nb, 15);
    start[0] = 1'b0;
    reset = 1'b1;
    #1;
    check_idle("t5_in_reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done[0]) nd++;
      if (busy[0]) nb++;
    end
    chk("t5_no_done", nd, 0);
    chk("t5_busy_after", nb, 15);
    check_idle("t5_after");
    full_run("t5_rerun", 12'h800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
